// File: rtl/sysid_checker_pkg.sv
// -----------------------------------------------------------------------------
// sysid_checker_pkg
// Shared definitions for the sysid checker: the FSM state type, the default
// expected ID/timestamp words and a small state-decode helper.
// -----------------------------------------------------------------------------
package sysid_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_EXPECTED_ID    = 32'd17734393;
    localparam logic [31:0] DEFAULT_EXPECTED_TS    = 32'd1318966812;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd255;

    // True in the states that hold a read on the bus.
    function automatic logic f_is_read_state(input state_t s);
        return (s == RD_ID) || (s == RD_TS);
    endfunction

endpackage

// File: rtl/sysid_checker_timeout.sv
// -----------------------------------------------------------------------------
// sysid_checker_timeout
// Stall counter for one bus read. Counts enabled (stalled) cycles, clears on
// request, and flags the stalled cycle that would bring the count to
// TIMEOUT_CYCLES.
//
// Ports
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_clear     synchronous clear (new check or accepted read)
//   i_enable    count this cycle (read stalled by the slave)
//   o_terminal  this stalled cycle is the TIMEOUT_CYCLES-th in a row
// -----------------------------------------------------------------------------
module sysid_checker_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    // The count before the final stalled cycle; legal TIMEOUT_CYCLES is 1..65535.
    localparam logic [15:0] TC_VALUE = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [15:0] r_count;

    // Stall counter: clear wins over increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 16'd0;
        end else if (i_clear) begin
            r_count <= 16'd0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_terminal = i_enable && (r_count == TC_VALUE);

endmodule

// File: rtl/sysid_checker.sv
// -----------------------------------------------------------------------------
// sysid_checker
// Reads the system ID (address 0) and, optionally, the build timestamp
// (address 1) from an Avalon-MM sysid slave and compares them with the
// expected values. Results are sticky until the next check starts.
//
// Build option: define SYSID_CHECKER_TS_CHECK_EN to include the timestamp
// read and ts_err; without it the ID read goes straight to DONE, address 1
// is never issued and ts_err stays 0.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle request to run a check (ignored while busy)
//   avm_address/avm_read  Avalon-MM read request (held stable under waitrequest)
//   avm_readdata          read data, valid when avm_read=1 and waitrequest=0
//   avm_waitrequest       slave stall
//   busy, done, pass      check running / finished (sticky) / result OK (sticky)
//   id_err, ts_err,
//   timeout_err           sticky failure causes
//   id_value              last captured ID word
// -----------------------------------------------------------------------------
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_err,
    output logic        ts_err,
    output logic        timeout_err,
    output logic [31:0] id_value
);

`ifdef SYSID_CHECKER_TS_CHECK_EN
    localparam bit TS_CHECK_EN = 1'b1;
`else
    localparam bit TS_CHECK_EN = 1'b0;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_first;
    logic        r_busy;
    logic        r_addr;
    logic        r_done;
    logic        r_pass;
    logic        r_id_err;
    logic        r_ts_err;
    logic        r_timeout_err;
    logic [31:0] r_id_value;

    logic        w_id_err_nxt;
    logic        w_ts_err_nxt;
    logic        w_to_err_nxt;
    logic [31:0] w_id_value_nxt;
    logic        w_cnt_clear;
    logic        w_stall;
    logic        w_timeout;
    logic        w_done_nxt;

    assign w_stall = f_is_read_state(r_state) && avm_waitrequest;

    sysid_checker_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk      (clk),
        .i_rst_n    (reset_n),
        .i_clear    (w_cnt_clear),
        .i_enable   (w_stall),
        .o_terminal (w_timeout)
    );

    // Marks the first clock after reset release for the auto-start check.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next values of the sticky result flags.
    always_comb begin
        w_state_nxt    = r_state;
        w_id_err_nxt   = r_id_err;
        w_ts_err_nxt   = r_ts_err;
        w_to_err_nxt   = r_timeout_err;
        w_id_value_nxt = r_id_value;
        w_cnt_clear    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start || (AUTO_START && r_first)) begin
                    w_state_nxt  = RD_ID;
                    w_id_err_nxt = 1'b0;
                    w_ts_err_nxt = 1'b0;
                    w_to_err_nxt = 1'b0;
                    w_cnt_clear  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    w_id_value_nxt = avm_readdata;
                    w_id_err_nxt   = (avm_readdata != EXPECTED_ID);
                    w_cnt_clear    = 1'b1;
                    w_state_nxt    = TS_CHECK_EN ? RD_TS : DONE;
                end else if (w_timeout) begin
                    w_to_err_nxt = 1'b1;
                    w_state_nxt  = DONE;
                end else begin
                    w_state_nxt = RD_ID;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    w_ts_err_nxt = TS_CHECK_EN && (avm_readdata != EXPECTED_TS);
                    w_cnt_clear  = 1'b1;
                    w_state_nxt  = DONE;
                end else if (w_timeout) begin
                    w_to_err_nxt = 1'b1;
                    w_state_nxt  = DONE;
                end else begin
                    w_state_nxt = RD_TS;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt  = RD_ID;
                    w_id_err_nxt = 1'b0;
                    w_ts_err_nxt = 1'b0;
                    w_to_err_nxt = 1'b0;
                    w_cnt_clear  = 1'b1;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_done_nxt = (w_state_nxt == DONE);

    // Output registers, loaded from the next state so every output is a flop
    // and reset forces all of them (including avm_read) low at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy        <= 1'b0;
            r_addr        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_id_err      <= 1'b0;
            r_ts_err      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_id_value    <= 32'd0;
        end else begin
            r_busy        <= f_is_read_state(w_state_nxt);
            r_addr        <= (w_state_nxt == RD_TS);
            r_done        <= w_done_nxt;
            r_pass        <= w_done_nxt && !(w_id_err_nxt || w_ts_err_nxt || w_to_err_nxt);
            r_id_err      <= w_id_err_nxt;
            r_ts_err      <= w_ts_err_nxt;
            r_timeout_err <= w_to_err_nxt;
            r_id_value    <= w_id_value_nxt;
        end
    end

    // A read is on the bus exactly while the checker is busy.
    assign avm_read    = r_busy;
    assign avm_address = r_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign id_err      = r_id_err;
    assign ts_err      = TS_CHECK_EN ? r_ts_err : 1'b0;
    assign timeout_err = r_timeout_err;
    assign id_value    = r_id_value;

endmodule

// File: tb/tb_sysid_checker.sv
`timescale 1ns/1ps
module tb_sysid_checker;

`ifdef SYSID_CHECKER_TS_CHECK_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    localparam int          TO     = 4;
    localparam logic [31:0] EXP_ID = 32'd17734393;
    localparam logic [31:0] EXP_TS = 32'd1318966812;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_err, ts_err, timeout_err;
    logic [31:0] id_value;

    // second instance, AUTO_START=0, zero-wait slave with good data
    logic        m_start;
    logic        m_address, m_read, m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_busy, m_done, m_pass, m_id_err, m_ts_err, m_to_err;
    logic [31:0] m_id_value;

    always #5 clk = ~clk;

    sysid_checker #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .pass(pass), .id_err(id_err), .ts_err(ts_err),
        .timeout_err(timeout_err), .id_value(id_value)
    );

    sysid_checker #(.AUTO_START(1'b0)) dut_manual (
        .clk(clk), .reset_n(reset_n), .start(m_start),
        .avm_address(m_address), .avm_read(m_read),
        .avm_readdata(m_readdata), .avm_waitrequest(m_waitrequest),
        .busy(m_busy), .done(m_done), .pass(m_pass), .id_err(m_id_err), .ts_err(m_ts_err),
        .timeout_err(m_to_err), .id_value(m_id_value)
    );

    assign m_waitrequest = 1'b0;
    assign m_readdata    = m_address ? EXP_TS : EXP_ID;

    // ---------------- slave model ----------------
    logic [31:0] sl_id, sl_ts;
    int          sl_waits;
    int          sl_cnt;

    assign avm_waitrequest = avm_read && (sl_cnt < sl_waits);
    assign avm_readdata    = avm_address ? sl_ts : sl_id;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        sl_cnt <= 0;
        else if (avm_read && avm_waitrequest) sl_cnt <= sl_cnt + 1;
        else                                 sl_cnt <= 0;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        id_err;
        logic        ts_err;
        logic        to_err;
        logic        pass;
        logic [31:0] id_value;
    } res_t;

    res_t        exp_res_q[$];
    logic        exp_addr_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] last_id = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: accepted reads, stall stability, completed checks.
    initial begin : monitor
        int   stall_n    = 0;
        logic prev_stall = 1'b0;
        logic prev_addr  = 1'b0;
        logic prev_done  = 1'b0;
        res_t r;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                stall_n    = 0;
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (prev_stall) begin
                    if (stall_n < TO) begin
                        check("read_held", avm_read, 1);
                        check("addr_held", avm_address, prev_addr);
                    end else begin
                        check("read_drop_after_timeout", avm_read, 0);
                    end
                end
                if (avm_read && !avm_waitrequest) begin
                    if (exp_addr_q.size() == 0) fail($sformatf("unexpected_read addr=%0d", avm_address));
                    else check("read_addr", avm_address, exp_addr_q.pop_front());
                    stall_n    = 0;
                    prev_stall = 1'b0;
                end else if (avm_read) begin
                    stall_n++;
                    prev_stall = 1'b1;
                    prev_addr  = avm_address;
                end else begin
                    stall_n    = 0;
                    prev_stall = 1'b0;
                end
                if (done && !prev_done) begin
                    if (exp_res_q.size() == 0) begin
                        fail("unexpected_done");
                    end else begin
                        r = exp_res_q.pop_front();
                        check("id_err",      id_err,      r.id_err);
                        check("ts_err",      ts_err,      r.ts_err);
                        check("timeout_err", timeout_err, r.to_err);
                        check("pass",        pass,        r.pass);
                        check("id_value",    id_value,    r.id_value);
                        check("busy_at_done", busy,       0);
                    end
                end
                prev_done = done;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic arm(input logic [31:0] id, input logic [31:0] ts, input int waits,
                       input bit e_id, input bit e_ts, input bit e_to, output int lat);
        res_t r;
        sl_id = id; sl_ts = ts; sl_waits = waits;
        r.id_err   = e_id;
        r.ts_err   = e_ts & TS_EN;
        r.to_err   = e_to;
        r.pass     = ~(r.id_err | r.ts_err | r.to_err);
        r.id_value = e_to ? last_id : id;
        if (!e_to) begin
            last_id = id;
            exp_addr_q.push_back(1'b0);
            if (TS_EN) exp_addr_q.push_back(1'b1);
        end
        exp_res_q.push_back(r);
        lat = e_to ? 1 + TO : 1 + (waits + 1) * (TS_EN ? 2 : 1);
    endtask

    // Called at the negedge where the check was launched; counts negedges to done.
    task automatic wait_done(input string name, input int lat, input bit poke);
        int n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            start = poke && (n == 2);
            if (done) break;
        end
        start = 1'b0;
        if (!done) fail({name, "_done_timeout"});
        else check({name, "_latency"}, n, lat);
    endtask

    task automatic run_vec(input string name, input logic [31:0] id, input logic [31:0] ts,
                           input int waits, input bit poke, input bit e_id, input bit e_ts, input bit e_to);
        int lat;
        arm(id, ts, waits, e_id, e_ts, e_to, lat);
        @(negedge clk);
        start = 1'b1;
        wait_done(name, lat, poke);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        reset_n = 1'b0; start = 1'b0; m_start = 1'b0;
        sl_id = EXP_ID; sl_ts = EXP_TS; sl_waits = 0;
        repeat (2) @(negedge clk);
        // reset state
        check("rst_avm_read", avm_read, 0);
        check("rst_busy",     busy,     0);
        check("rst_done",     done,     0);
        check("rst_pass",     pass,     0);
        check("rst_id_value", id_value, 0);
        check("rst_m_read",   m_read,   0);

        // auto-start check after reset release
        arm(EXP_ID, EXP_TS, 0, 1'b0, 1'b0, 1'b0, lat);
        reset_n = 1'b1;
        wait_done("auto_good", lat, 1'b0);

        // AUTO_START=0 instance stays idle until started
        check("manual_idle_busy", m_busy, 0);
        check("manual_idle_read", m_read, 0);
        check("manual_idle_done", m_done, 0);
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        repeat (2) @(negedge clk);
        check("manual_done",  m_done,     1);
        check("manual_pass",  m_pass,     1);
        check("manual_id",    m_id_value, EXP_ID);

        run_vec("bad_id",    32'd5,         EXP_TS,        0,    1'b0, 1'b1, 1'b0, 1'b0);
        run_vec("bad_ts",    EXP_ID,        32'h1234_5678, 0,    1'b0, 1'b0, 1'b1, 1'b0);
        run_vec("timeout",   32'hDEAD_BEEF, EXP_TS,        1000, 1'b0, 1'b0, 1'b0, 1'b1);
        run_vec("wait3",     EXP_ID,        EXP_TS,        3,    1'b1, 1'b0, 1'b0, 1'b0);
        run_vec("both_bad",  32'hFFFF_FFFF, 32'h0,         1,    1'b0, 1'b1, 1'b1, 1'b0);

        // reset in the middle of a read (RD_TS when present, else RD_ID)
        sl_id = EXP_ID; sl_ts = EXP_TS; sl_waits = 2;
        if (TS_EN) exp_addr_q.push_back(1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (TS_EN ? 4 : 1) @(negedge clk);
        check("pre_reset_read", avm_read, 1);
        check("pre_reset_addr", avm_address, TS_EN);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_read",   avm_read,    0);
        check("mid_rst_addr",   avm_address, 0);
        check("mid_rst_busy",   busy,        0);
        check("mid_rst_id_err", id_err,      0);
        check("mid_rst_to_err", timeout_err, 0);
        check("mid_rst_idval",  id_value,    0);
        last_id = 32'd0;
        arm(EXP_ID, EXP_TS, 0, 1'b0, 1'b0, 1'b0, lat);
        @(negedge clk);
        reset_n = 1'b1;
        wait_done("after_reset", lat, 1'b0);

        repeat (3) @(negedge clk);
        check("addr_queue_drained",   exp_addr_q.size(), 0);
        check("result_queue_drained", exp_res_q.size(),  0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
